frame_tx_scheduler: RTL and testbench
=====================================

# frame_tx_scheduler

Round-robin frame scheduler feeding the 16-bit `data_in` port of `frame_detector`. Up to eight channel requesters each present a payload of 1–8 words. The block arbitrates between them, then emits one complete frame per grant: header, one-hot channel word, payload, CRC16 and trailer. It owns frame sequencing, inter-frame spacing and CRC generation so the detector only ever sees well-formed streams.

## Interface
- `NUM_CH`, 8: number of requesters; legal range 2..8, because the channel word is an 8-bit one-hot field.
- `GAP_CYCLES`, 1: number of 0x0000 idle words inserted after every trailer; legal range 1..15.
- `clk_in`  in  1: single clock; every register is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  NUM_CH: level request per channel; held until the matching `gnt`.
- `req_payload`  in  NUM_CH*128: payload per channel; channel c occupies `[128*c +: 128]` and is right-justified.
- `req_words`  in  NUM_CH*3: payload word count minus 1 per channel; channel c occupies `[3*c +: 3]`.
- `hold`  in  1: when high, a new frame is not started (drive from `fifo_full`).
- `gnt`  out  NUM_CH: one-hot, one-cycle pulse; payload and length are latched on this edge.
- `data_out`  out  16: word stream to `frame_detector.data_in`; registered.
- `frame_active`  out  1: high from the HDR_H cycle through the TRL_L cycle inclusive.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, HDR_H, HDR_L, CHAN, DATA, CRC, TRL_H, TRL_L, GAP. Each state lasts one cycle, except DATA (N cycles) and GAP (`GAP_CYCLES` cycles).
- `data_out` per state:
  - HDR_H 0xE0E0; HDR_L 0xE0E0.
  - CHAN `{8'h00, onehot(ch)}`.
  - DATA word k (k=0..N-1) = `payload[16*(N-1-k) +: 16]`, i.e. big-endian, most significant word first.
  - CRC: accumulated CRC.
  - TRL_H 0x0E0E; TRL_L 0x0E0E.
  - IDLE and GAP: 0x0000.
- Arbitration:
  - Runs in IDLE, and in the last GAP cycle, whenever `hold`=0 and `|req`=1.
  - Search starts at `rr_ptr` and wraps upward; the first set bit wins.
  - `rr_ptr` then becomes winner+1 mod NUM_CH.
- Transitions:
  - IDLE→HDR_H on a grant.
  - Last GAP cycle → HDR_H on a grant, otherwise → IDLE.
  - DATA→CRC after N words.
  - TRL_L→GAP.
- CRC16-CCITT: polynomial 0x1021, init 0x0000, no reflection, no final XOR.
  - Updated 16 bits per cycle over the DATA words only, using the same parallel equations as the detector's checker.
  - Cleared on every grant.
- `hold` is sampled only at arbitration points. Asserting it mid-frame has no effect, because the detector cannot backpressure a frame in flight.
- A channel that drops `req` before its grant is simply skipped; no error is raised.

## Timing
- Grant latency: `req` sampled high in IDLE at edge t gives `gnt` and `data_out`=0xE0E0 both visible after edge t.
- Frame length is N+6 cycles.
- Back-to-back frames are separated by exactly `GAP_CYCLES` words of 0x0000.
- Reset value of every output is 0: `gnt`=0, `data_out`=0x0000, `frame_active`=0, `busy`=0. After reset, state is IDLE and `rr_ptr`=0.
- `rst` asserted mid-frame:
  - The frame is truncated.
  - `data_out` is 0x0000 from the next cycle.
  - No trailer is emitted; the detector's resync handles the partial frame.
- A grant coinciding with `rst` is discarded.

## Configuration
- `FRAME_ERR_INJ_EN` defined:
  - Adds input port `err_inj` (1 bit), sampled at grant.
  - If `err_inj` was high at grant, the CRC word of that frame is transmitted bit-inverted.
- `FRAME_ERR_INJ_EN` undefined: the port is absent and the CRC word is always correct.

## Structure
- Package `frame_pkg` holds:
  - `FRAME_HEADER` = 32'hE0E0E0E0 and `FRAME_TRAILER` = 32'h0E0E0E0E.
  - The state enum `tx_state_t`.
  - Function `crc16_upd(crc, word)`, shared with the detector's checker.
- Sub-module `crc16_par16` holds the CRC register, with clear and enable inputs and a single `crc_update` function instance.
- The arbiter and FSM stay in the top module.

## Test plan
- **Single frame:** ch0, `req_words`=0, payload 0xA55A → stream E0E0, E0E0, 0001, A55A, crc16_upd(0,A55A), 0E0E, 0E0E; then `gap_cycles` words of 0000. `gnt`=0x01 for exactly one cycle.
- **Maximum payload:** ch1, 8 words 0x0123…3210 → 14-cycle frame, words in big-endian order; the detector in loopback raises `crc_valid` with no `crc_err`.
- **Simultaneous requests:** ch2 and ch3 held together from reset → ch2 frame, exactly `gap_cycles` zeros, then ch3 frame; 8'h04 then 8'h08 in the CHAN slots.
- **Fairness:** all 8 channels held high for 16 frames → grant order 0,1,…,7,0,…,7 with no repeats before wrap.
- **Hold:** `hold`=1 with ch4 requesting → `data_out` stays 0000 and `busy` stays 0. Releasing `hold` starts ch4's frame on the next edge.
- **Reset mid-frame:** `rst` pulsed during DATA word 2 of 4 → outputs 0 on the next cycle, `rr_ptr` back to 0. A pending ch5 request is granted at the first IDLE after `rst` deasserts.

Source files
------------

// File: rtl/frame_pkg.sv
// frame_pkg: shared definitions for the frame transmit path.
//   FRAME_HEADER / FRAME_TRAILER : 32-bit delimiters, sent as two 16-bit words.
//   tx_state_t                   : scheduler FSM states.
//   crc16_upd(crc, word)         : CRC16-CCITT (poly 0x1021, no reflection),
//                                  16 data bits per call, MSB first. The
//                                  detector's checker uses this same function.
package frame_pkg;

  localparam logic [31:0] FRAME_HEADER  = 32'hE0E0E0E0;
  localparam logic [31:0] FRAME_TRAILER = 32'h0E0E0E0E;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_HDR_H = 4'd1,
    ST_HDR_L = 4'd2,
    ST_CHAN  = 4'd3,
    ST_DATA  = 4'd4,
    ST_CRC   = 4'd5,
    ST_TRL_H = 4'd6,
    ST_TRL_L = 4'd7,
    ST_GAP   = 4'd8
  } tx_state_t;

  // Bit-serial loop unrolled by synthesis into the parallel XOR network.
  function automatic logic [15:0] crc16_upd(input logic [15:0] crc,
                                            input logic [15:0] word);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ word[i]) c = (c << 1) ^ 16'h1021;
      else                 c = c << 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_tx_scheduler_if.sv
// frame_tx_scheduler_if: requester/stream bundle of the frame scheduler.
//   req, req_payload, req_words, hold : requester side into the scheduler
//   gnt, data_out, frame_active, busy : scheduler outputs
//   state_dbg, rr_ptr_dbg             : FSM state and round-robin pointer
// Handshake: a requester raises req[c] with payload/length stable and holds
// it until it sees gnt[c]; gnt[c] is a single-cycle pulse and the payload and
// length are captured on that same edge. Dropping req before the grant simply
// withdraws the request. There is no backpressure once a frame has started.
interface frame_tx_scheduler_if #(
  parameter int NUM_CH = 8
);
  logic [NUM_CH-1:0]     req;
  logic [NUM_CH*128-1:0] req_payload;
  logic [NUM_CH*3-1:0]   req_words;
  logic                  hold;
  logic [NUM_CH-1:0]     gnt;
  logic [15:0]           data_out;
  logic                  frame_active;
  logic                  busy;
  frame_pkg::tx_state_t  state_dbg;
  logic [2:0]            rr_ptr_dbg;

  modport master (
    input  req, req_payload, req_words, hold,
    output gnt, data_out, frame_active, busy, state_dbg, rr_ptr_dbg
  );

  modport slave (
    output req, req_payload, req_words, hold,
    input  gnt, data_out, frame_active, busy, state_dbg, rr_ptr_dbg
  );
endinterface

// File: rtl/crc16_par16.sv
// crc16_par16: CRC16-CCITT register, one 16-bit word per enabled cycle.
//   clk_in, rst : clock, synchronous active-high reset (register -> 0)
//   clr         : load the init value 0x0000 (wins over en)
//   en          : fold data_in into the running CRC
//   data_in     : word to accumulate
//   crc_out     : current CRC register value
module crc16_par16
  import frame_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] data_in,
  output logic [15:0] crc_out
);
  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr)     crc_d = 16'h0000;
    else if (en) crc_d = crc16_upd(crc_q, data_in);
  end

  always_ff @(posedge clk_in) begin
    if (rst) crc_q <= 16'h0000;
    else     crc_q <= crc_d;
  end

  assign crc_out = crc_q;
endmodule

// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: round-robin arbiter plus frame generator for the
// frame_detector data_in stream. Frame = HDR_H, HDR_L, CHAN (one-hot),
// N payload words (MS word first), CRC16, TRL_H, TRL_L, then GAP_CYCLES
// zero words.
//   clk_in, rst : clock, synchronous active-high reset
//   err_inj     : only with FRAME_ERR_INJ_EN defined; sampled at grant, inverts
//                 that frame's CRC word
//   bus         : frame_tx_scheduler_if master (requests, grant, stream,
//                 status, debug state / pointer)
// Parameters: NUM_CH (2..8), GAP_CYCLES (1..15).
// All outputs are registers computed from the next state, so data_out always
// shows the word belonging to the current state_q.
module frame_tx_scheduler
  import frame_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int GAP_CYCLES = 1
)(
  input  logic clk_in,
  input  logic rst,
`ifdef FRAME_ERR_INJ_EN
  input  logic err_inj,
`endif
  frame_tx_scheduler_if.master bus
);
  localparam int         PTR_W    = $clog2(NUM_CH);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  tx_state_t          state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [127:0]       payload_q, payload_d;
  logic [2:0]         words_q, words_d;
  logic [2:0]         idx_q, idx_d;
  logic [3:0]         gap_q, gap_d;
  logic [7:0]         chan_oh_q, chan_oh_d;
  logic [NUM_CH-1:0]  gnt_q, gnt_d;
  logic [15:0]        data_q, data_d;
  logic               frame_active_q, frame_active_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               arb_found;
  logic [PTR_W-1:0]   arb_win;
  logic [PTR_W:0]     arb_sum;
  logic               arb_point;
  logic               grant;
  logic [15:0]        pay_word;
  logic [15:0]        crc_val;
  logic               crc_clr, crc_en;

  // Round-robin search from rr_ptr upward with wrap; first requester wins.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    arb_sum   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      arb_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (arb_sum >= (PTR_W+1)'(NUM_CH)) arb_sum = arb_sum - (PTR_W+1)'(NUM_CH);
      if (!arb_found && bus.req[arb_sum[PTR_W-1:0]]) begin
        arb_found = 1'b1;
        arb_win   = arb_sum[PTR_W-1:0];
      end
    end
  end

  // hold only matters at arbitration points; a frame in flight always completes.
  assign arb_point = (state_q == ST_IDLE) || (state_q == ST_GAP && gap_q == 4'd0);
  assign grant     = arb_point && !bus.hold && arb_found;

  // State register (and the datapath registers that travel with it).
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      payload_q      <= '0;
      words_q        <= '0;
      idx_q          <= '0;
      gap_q          <= '0;
      chan_oh_q      <= '0;
      gnt_q          <= '0;
      data_q         <= '0;
      frame_active_q <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      payload_q      <= payload_d;
      words_q        <= words_d;
      idx_q          <= idx_d;
      gap_q          <= gap_d;
      chan_oh_q      <= chan_oh_d;
      gnt_q          <= gnt_d;
      data_q         <= data_d;
      frame_active_q <= frame_active_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (grant) state_d = ST_HDR_H;
      ST_HDR_H: state_d = ST_HDR_L;
      ST_HDR_L: state_d = ST_CHAN;
      ST_CHAN:  state_d = ST_DATA;
      ST_DATA:  if (idx_q == 3'd0) state_d = ST_CRC;
      ST_CRC:   state_d = ST_TRL_H;
      ST_TRL_H: state_d = ST_TRL_L;
      ST_TRL_L: state_d = ST_GAP;
      ST_GAP:   if (gap_q == 4'd0) state_d = grant ? ST_HDR_H : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic, evaluated against state_d so the registered
  // outputs line up with the state they describe.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    payload_d = payload_q;
    words_d   = words_q;
    chan_oh_d = chan_oh_q;
    err_d     = err_q;
    gnt_d     = '0;
    idx_d     = idx_q;
    gap_d     = gap_q;
    crc_clr   = 1'b0;

    if (grant) begin
      gnt_d[arb_win] = 1'b1;
      rr_ptr_d  = (arb_win == PTR_W'(NUM_CH - 1)) ? '0 : arb_win + 1'b1;
      payload_d = bus.req_payload[128*arb_win +: 128];
      words_d   = bus.req_words[3*arb_win +: 3];
      chan_oh_d = 8'b1 << arb_win;
`ifdef FRAME_ERR_INJ_EN
      err_d     = err_inj;
`else
      err_d     = 1'b0;
`endif
      crc_clr   = 1'b1;
    end

    // idx counts down through the payload, MS word first.
    if (state_q == ST_CHAN)      idx_d = words_q;
    else if (state_q == ST_DATA) idx_d = idx_q - 3'd1;

    if (state_q == ST_TRL_L)                     gap_d = GAP_LAST;
    else if (state_q == ST_GAP && gap_q != 4'd0) gap_d = gap_q - 4'd1;

    pay_word = payload_q[16*idx_d +: 16];
    // The CRC register absorbs each word on the edge it is emitted, so in the
    // CRC state it already covers the whole payload.
    crc_en   = (state_d == ST_DATA);

    data_d = 16'h0000;
    unique case (state_d)
      ST_HDR_H: data_d = FRAME_HEADER[31:16];
      ST_HDR_L: data_d = FRAME_HEADER[15:0];
      ST_CHAN:  data_d = {8'h00, chan_oh_q};
      ST_DATA:  data_d = pay_word;
      ST_CRC:   data_d = err_q ? ~crc_val : crc_val;
      ST_TRL_H: data_d = FRAME_TRAILER[31:16];
      ST_TRL_L: data_d = FRAME_TRAILER[15:0];
      default:  data_d = 16'h0000;
    endcase

    frame_active_d = !(state_d inside {ST_IDLE, ST_GAP});
    busy_d         = (state_d != ST_IDLE);
  end

  crc16_par16 u_crc (
    .clk_in  (clk_in),
    .rst     (rst),
    .clr     (crc_clr),
    .en      (crc_en),
    .data_in (pay_word),
    .crc_out (crc_val)
  );

  assign bus.gnt          = gnt_q;
  assign bus.data_out     = data_q;
  assign bus.frame_active = frame_active_q;
  assign bus.busy         = busy_q;
  assign bus.state_dbg    = state_q;
  assign bus.rr_ptr_dbg   = 3'(rr_ptr_q);

endmodule

// File: tb/tb_frame_tx_scheduler.sv
module tb_frame_tx_scheduler;
  import frame_pkg::*;

  localparam int GAP = 2;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  logic err_inj = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];

  frame_tx_scheduler_if #(.NUM_CH(8)) bus ();

  frame_tx_scheduler #(.NUM_CH(8), .GAP_CYCLES(GAP)) dut (
    .clk_in (clk_in),
    .rst    (rst),
`ifdef FRAME_ERR_INJ_EN
    .err_inj(err_inj),
`endif
    .bus    (bus)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver helpers
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference CRC: XOR the word into the register, then 16 plain shifts.
  function automatic logic [15:0] ref_crc(input logic [15:0] c_in, input logic [15:0] w);
    logic [15:0] c;
    c = c_in ^ w;
    repeat (16) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  task automatic set_req(input int ch, input logic [127:0] payload, input logic [2:0] words);
    bus.req_payload[128*ch +: 128] = payload;
    bus.req_words[3*ch +: 3]       = words;
    bus.req[ch]                    = 1'b1;
  endtask

  task automatic wait_gnt(input string name, output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.gnt != '0) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      failures++;
      $display("FAIL %s grant timeout after 20 cycles", name);
    end
  endtask

  // Called in the grant cycle: checks gnt, then the whole frame word by word.
  task automatic check_frame(input string name, input int ch, input logic [127:0] payload,
                             input logic [2:0] words, input logic [7:0] exp_gnt, input bit drop);
    int n;
    logic [15:0] w, crc;
    n   = int'(words) + 1;
    crc = 16'h0000;
    exp_q.push_back(16'hE0E0);
    exp_q.push_back(16'hE0E0);
    exp_q.push_back({8'h00, exp_gnt});
    for (int k = 0; k < n; k++) begin
      w   = payload[16*(n-1-k) +: 16];
      crc = ref_crc(crc, w);
      exp_q.push_back(w);
    end
    exp_q.push_back(crc);
    exp_q.push_back(16'h0E0E);
    exp_q.push_back(16'h0E0E);
    chk({name, "_gnt"}, {8'h00, bus.gnt}, {8'h00, exp_gnt});
    if (drop) bus.req[ch] = 1'b0;
    for (int k = 0; k < n + 6; k++) begin
      if (k > 0) step();
      chk({name, "_word"}, bus.data_out, exp_q.pop_front());
      chk({name, "_frame_active"}, {15'h0, bus.frame_active}, 16'h0001);
      if (k == 1) chk({name, "_gnt_pulse"}, {8'h00, bus.gnt}, 16'h0000);
    end
  endtask

  task automatic expect_gap(input string name);
    for (int i = 0; i < GAP; i++) begin
      step();
      chk({name, "_gap_data"}, bus.data_out, 16'h0000);
      chk({name, "_gap_fa"}, {15'h0, bus.frame_active}, 16'h0000);
      chk({name, "_gap_busy"}, {15'h0, bus.busy}, 16'h0001);
    end
  endtask

  task automatic expect_idle(input string name);
    step();
    chk({name, "_idle_busy"}, {15'h0, bus.busy}, 16'h0000);
    chk({name, "_idle_data"}, bus.data_out, 16'h0000);
    chk({name, "_idle_state"}, 16'(bus.state_dbg), 16'(ST_IDLE));
  endtask

  typedef struct {
    int           ch;
    logic [127:0] payload;
    logic [2:0]   words;
    logic [7:0]   exp_gnt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat;
    bus.req         = '0;
    bus.req_payload = '0;
    bus.req_words   = '0;
    bus.hold        = 1'b0;

    vecs[0] = '{ch: 0, payload: 128'hA55A, words: 3'd0, exp_gnt: 8'h01};
    vecs[1] = '{ch: 1, payload: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, words: 3'd7, exp_gnt: 8'h02};
    vecs[2] = '{ch: 3, payload: 128'h1111_2222_3333, words: 3'd2, exp_gnt: 8'h08};
    vecs[3] = '{ch: 7, payload: 128'hBEEF_0000, words: 3'd1, exp_gnt: 8'h80};
    vecs[4] = '{ch: 6, payload: 128'hFFFF_0001_8000_7FFF_FFFF, words: 3'd4, exp_gnt: 8'h40};

    // reset state
    repeat (3) step();
    chk("rst_gnt", {8'h00, bus.gnt}, 16'h0000);
    chk("rst_data", bus.data_out, 16'h0000);
    chk("rst_fa", {15'h0, bus.frame_active}, 16'h0000);
    chk("rst_busy", {15'h0, bus.busy}, 16'h0000);
    chk("rst_state", 16'(bus.state_dbg), 16'(ST_IDLE));
    chk("rst_rr", {13'h0, bus.rr_ptr_dbg}, 16'h0000);
    rst = 1'b0;
    expect_idle("post_rst");

    // table-driven single frames
    for (int v = 0; v < 5; v++) begin
      set_req(vecs[v].ch, vecs[v].payload, vecs[v].words);
      wait_gnt("vec", lat);
      chk("vec_latency", 16'(lat), 16'd1);
      check_frame("vec", vecs[v].ch, vecs[v].payload, vecs[v].words, vecs[v].exp_gnt, 1'b1);
      expect_gap("vec");
      expect_idle("vec");
    end

    // simultaneous ch2/ch3 held from reset: back-to-back with exactly GAP zeros
    rst = 1'b1;
    set_req(2, 128'h1234_5678, 3'd1);
    set_req(3, 128'h9ABC, 3'd0);
    step();
    step();
    chk("sim_rr_rst", {13'h0, bus.rr_ptr_dbg}, 16'h0000);
    rst = 1'b0;
    step();
    check_frame("sim_ch2", 2, 128'h1234_5678, 3'd1, 8'h04, 1'b1);
    expect_gap("sim");
    step();
    check_frame("sim_ch3", 3, 128'h9ABC, 3'd0, 8'h08, 1'b1);
    expect_gap("sim_end");
    expect_idle("sim");

    // fairness: all channels held for 16 frames
    rst = 1'b1;
    for (int c = 0; c < 8; c++) set_req(c, 128'(16'h1000 + c), 3'd0);
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      if (i == 15) bus.req = '0;
      check_frame("fair", i % 8, 128'(16'h1000 + (i % 8)), 3'd0, 8'(1 << (i % 8)), 1'b0);
      expect_gap("fair");
    end
    expect_idle("fair");

    // hold blocks a new frame; release starts it on the next edge
    bus.hold = 1'b1;
    set_req(4, 128'h4444_0004, 3'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_data", bus.data_out, 16'h0000);
      chk("hold_busy", {15'h0, bus.busy}, 16'h0000);
    end
    bus.hold = 1'b0;
    step();
    check_frame("hold_rel", 4, 128'h4444_0004, 3'd1, 8'h10, 1'b1);
    expect_gap("hold_rel");
    expect_idle("hold_rel");

    // reset during DATA word 2 of 4, ch5 pending
    set_req(1, 128'hAAAA_BBBB_CCCC_DDDD, 3'd3);
    wait_gnt("mid", lat);
    chk("mid_gnt", {8'h00, bus.gnt}, 16'h0002);
    bus.req[1] = 1'b0;
    set_req(5, 128'h5555_6666, 3'd1);
    step(); chk("mid_hdrl", bus.data_out, 16'hE0E0);
    step(); chk("mid_chan", bus.data_out, 16'h0002);
    step(); chk("mid_d0", bus.data_out, 16'hAAAA);
    step(); chk("mid_d1", bus.data_out, 16'hBBBB);
    step(); chk("mid_d2", bus.data_out, 16'hCCCC);
    rst = 1'b1;
    step();
    chk("mid_rst_data", bus.data_out, 16'h0000);
    chk("mid_rst_gnt", {8'h00, bus.gnt}, 16'h0000);
    chk("mid_rst_fa", {15'h0, bus.frame_active}, 16'h0000);
    chk("mid_rst_busy", {15'h0, bus.busy}, 16'h0000);
    chk("mid_rst_rr", {13'h0, bus.rr_ptr_dbg}, 16'h0000);
    rst = 1'b0;
    step();
    chk("mid_ch5_rr", {13'h0, bus.rr_ptr_dbg}, 16'h0006);
    check_frame("mid_ch5", 5, 128'h5555_6666, 3'd1, 8'h20, 1'b1);
    expect_gap("mid_ch5");
    expect_idle("mid_ch5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
